// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: drives a 1-cycle-latency instruction memory and buffers
// fetched words in a QDEPTH-entry prefetch queue presented to decode via valid/ready.
module ifu_prefetch #(
    parameter int unsigned XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned IMEM_AW  = 8,
    parameter int unsigned QDEPTH   = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_pc_plus_4,
    output logic [31:0]        out_instr
);

    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam logic [XLEN-1:0] RESET_PC_X = {RESET_PC[XLEN-1:2], 2'b00};

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pc_mem    [QDEPTH];
    logic [31:0]     instr_mem [QDEPTH];

    logic            pop;
    logic            push;
    logic            issue;
    logic            credit_ok;
    logic [CW:0]     occupancy;
    logic [XLEN-1:0] redirect_target;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(QDEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign redirect_target = redirect_pc & ~(XLEN'(3));

    assign out_valid = !sys_rst && (count != '0);
    assign pop       = out_valid && out_ready;

    // Counting the word leaving this cycle lets a full queue keep issuing, which
    // is what sustains one instruction per cycle even at QDEPTH=2.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    assign credit_ok = occupancy < (CW + 1)'(QDEPTH);

    assign issue     = !sys_rst && !redirect_valid && credit_ok;
    assign imem_en   = issue;
    assign imem_addr = fetch_pc[IMEM_AW+1:2];
    assign push      = inflight && !redirect_valid;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            fetch_pc    <= RESET_PC_X;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_target;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + XLEN'(4);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && push) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    assign out_pc        = out_valid ? pc_mem[rd_ptr] : '0;
    assign out_pc_plus_4 = out_valid ? (pc_mem[rd_ptr] + XLEN'(4)) : '0;
    assign out_instr     = out_valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: a 64-bit QDEPTH=4 unit checked by a scoreboard of the
// sequential PC stream, plus a 32-bit QDEPTH=2 unit exercising PC wrap.
module tb_ifu_prefetch;

    localparam logic [63:0] RESET_PC   = 64'h8000_0000;
    localparam int          QDEPTH     = 4;
    localparam logic [31:0] RESET_PC_B = 32'hFFFF_FFF8;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_pc_plus_4;
    logic [31:0] out_instr;

    logic        imem_en_b;
    logic [7:0]  imem_addr_b;
    logic [31:0] imem_rdata_b = '0;
    logic        out_valid_b;
    logic [31:0] out_pc_b;
    logic [31:0] out_pc_plus_4_b;
    logic [31:0] out_instr_b;

    logic [31:0] mem   [256];
    logic [31:0] mem_b [256];
    exp_t        exp_q [$];
    int          n_vec  = 0;
    int          n_miss = 0;

    ifu_prefetch #(
        .XLEN(64), .RESET_PC(RESET_PC), .IMEM_AW(8), .QDEPTH(QDEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc_plus_4(out_pc_plus_4), .out_instr(out_instr)
    );

    ifu_prefetch #(
        .XLEN(32), .RESET_PC(64'(RESET_PC_B)), .IMEM_AW(8), .QDEPTH(2)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_en(imem_en_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .out_valid(out_valid_b), .out_ready(1'b1),
        .out_pc(out_pc_b), .out_pc_plus_4(out_pc_plus_4_b), .out_instr(out_instr_b)
    );

    always #5 sys_clk = ~sys_clk;

    // Registered instruction memories: data appears the cycle after the request.
    always @(posedge sys_clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
        if (imem_en_b) imem_rdata_b <= mem_b[imem_addr_b];
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void restart(input logic [63:0] start);
        logic [63:0] pc;
        pc = {start[63:2], 2'b00};
        exp_q.delete();
        for (int k = 0; k < 512; k++) begin
            exp_q.push_back('{pc: pc, instr: mem[pc[9:2]]});
            pc = pc + 64'd4;
        end
    endfunction

    task automatic apply_stimulus(input logic rst, input logic redir, input logic [63:0] rpc, input logic rdy);
        @(posedge sys_clk);
        #1;
        sys_rst        = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        if (rst) restart(RESET_PC);
        else if (redir) restart(rpc);
    endtask

    // Monitor for the main unit: pops the expected stream on each live handshake.
    int          outstanding = 0;
    logic        hold_prev   = 1'b0;
    logic [63:0] hold_pc;
    logic [31:0] hold_instr;
    always @(negedge sys_clk) begin
        exp_t e;
        if (!out_valid)
            check_output("empty_zero", out_pc | out_pc_plus_4 | {32'b0, out_instr}, 64'd0);
        if (hold_prev && !sys_rst) begin
            check_output("hold_valid", {63'b0, out_valid}, 64'd1);
            check_output("hold_pc", out_pc, hold_pc);
            check_output("hold_instr", {32'b0, out_instr}, {32'b0, hold_instr});
        end
        if (sys_rst) check_output("rst_valid", {63'b0, out_valid}, 64'd0);
        if (sys_rst || redirect_valid) begin
            check_output("issue_blocked", {63'b0, imem_en}, 64'd0);
            outstanding = 0;
            hold_prev   = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL sb_empty: handshake pc %h, expected no entry", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check_output("sb_pc", out_pc, e.pc);
                    check_output("sb_pc4", out_pc_plus_4, e.pc + 64'd4);
                    check_output("sb_instr", {32'b0, out_instr}, {32'b0, e.instr});
                end
            end
            outstanding = outstanding + int'(imem_en) - int'(out_valid && out_ready);
            check_output("credit_bound", {63'b0, outstanding <= QDEPTH}, 64'd1);
            hold_prev  = out_valid && !out_ready;
            hold_pc    = out_pc;
            hold_instr = out_instr;
        end
    end

    // Monitor for the 32-bit unit, always ready: a plain sequential PC model.
    logic [31:0] pc_b_model;
    logic [31:0] pc4_b_model;
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            pc_b_model = RESET_PC_B;
            check_output("b_rst_valid", {63'b0, out_valid_b}, 64'd0);
        end else if (out_valid_b) begin
            pc4_b_model = pc_b_model + 32'd4;
            check_output("b_pc", {32'b0, out_pc_b}, {32'b0, pc_b_model});
            check_output("b_pc4", {32'b0, out_pc_plus_4_b}, {32'b0, pc4_b_model});
            check_output("b_instr", {32'b0, out_instr_b}, {32'b0, mem_b[pc_b_model[9:2]]});
            pc_b_model = pc4_b_model;
        end
    end

    initial begin
        int          issues;
        int          valid_cnt;
        int          valid_cnt_b;
        int          lat;
        logic [63:0] target;
        logic        rst;
        logic        redir;

        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'h1000_0000 + 32'(i);
            mem_b[i] = 32'h2000_0000 + 32'(i);
        end
        sys_rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        restart(RESET_PC);

        // Reset release with decode always ready.
        apply_stimulus(1, 0, 0, 1);
        apply_stimulus(1, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        @(negedge sys_clk);
        check_output("a_c0_en", {63'b0, imem_en}, 64'd1);
        check_output("a_c0_valid", {63'b0, out_valid}, 64'd0);
        check_output("a_c0_addr_b", {56'b0, imem_addr_b}, 64'hFE);
        apply_stimulus(0, 0, 0, 1);
        @(negedge sys_clk);
        check_output("a_c1_valid", {63'b0, out_valid}, 64'd0);
        check_output("a_c1_addr_b", {56'b0, imem_addr_b}, 64'hFF);
        apply_stimulus(0, 0, 0, 1);
        @(negedge sys_clk);
        check_output("a_c2_valid", {63'b0, out_valid}, 64'd1);
        check_output("a_c2_pc", out_pc, RESET_PC);
        check_output("a_c2_addr_b", {56'b0, imem_addr_b}, 64'h00);
        check_output("a_c2_pc_b", {32'b0, out_pc_b}, 64'hFFFF_FFF8);
        apply_stimulus(0, 0, 0, 1);
        @(negedge sys_clk);
        check_output("a_c3_pc", out_pc, 64'h8000_0004);
        check_output("a_c3_pc_b", {32'b0, out_pc_b}, 64'hFFFF_FFFC);
        apply_stimulus(0, 0, 0, 1);
        @(negedge sys_clk);
        check_output("a_c4_pc_b", {32'b0, out_pc_b}, 64'h0);
        valid_cnt = 0;
        valid_cnt_b = 0;
        repeat (20) begin
            apply_stimulus(0, 0, 0, 1);
            @(negedge sys_clk);
            valid_cnt += int'(out_valid);
            valid_cnt_b += int'(out_valid_b);
        end
        check_output("a_stream", 64'(valid_cnt), 64'd20);
        check_output("a_stream_b", 64'(valid_cnt_b), 64'd20);

        // Backpressure from cycle 0: exactly QDEPTH issues, head held.
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        issues = 0;
        repeat (10) begin
            apply_stimulus(0, 0, 0, 0);
            @(negedge sys_clk);
            issues += int'(imem_en);
            if (out_valid) check_output("b_head", out_pc, RESET_PC);
        end
        check_output("b_issues", 64'(issues), 64'(QDEPTH));
        check_output("b_idle_en", {63'b0, imem_en}, 64'd0);
        check_output("b_full_valid", {63'b0, out_valid}, 64'd1);
        valid_cnt = 0;
        repeat (16) begin
            apply_stimulus(0, 0, 0, 1);
            @(negedge sys_clk);
            valid_cnt += int'(out_valid);
        end
        check_output("b_stream", 64'(valid_cnt), 64'd16);

        // Redirect with three queued entries and one fetch in flight.
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(0, 0, 0, 0);
            @(negedge sys_clk);
            if (k == 3) check_output("c_c3_en", {63'b0, imem_en}, 64'd1);
            if (k == 4) begin
                check_output("c_c4_en", {63'b0, imem_en}, 64'd0);
                check_output("c_c4_valid", {63'b0, out_valid}, 64'd1);
            end
        end
        apply_stimulus(0, 1, 64'h8000_0043, 0);
        @(negedge sys_clk);
        check_output("c_redir_en", {63'b0, imem_en}, 64'd0);
        apply_stimulus(0, 0, 0, 0);
        @(negedge sys_clk);
        check_output("c_r1_valid", {63'b0, out_valid}, 64'd0);
        check_output("c_r1_en", {63'b0, imem_en}, 64'd1);
        check_output("c_r1_addr", {56'b0, imem_addr}, 64'h10);
        apply_stimulus(0, 0, 0, 0);
        @(negedge sys_clk);
        check_output("c_r2_valid", {63'b0, out_valid}, 64'd0);
        apply_stimulus(0, 0, 0, 0);
        @(negedge sys_clk);
        check_output("c_r3_valid", {63'b0, out_valid}, 64'd1);
        check_output("c_r3_pc", out_pc, 64'h8000_0040);
        check_output("c_r3_instr", {32'b0, out_instr}, 64'h1000_0010);
        repeat (6) apply_stimulus(0, 0, 0, 1);

        // Redirect coinciding with a handshake; that handshake is void.
        repeat (3) begin
            repeat (4) apply_stimulus(0, 0, 0, 1);
            target = {$urandom(), $urandom()};
            apply_stimulus(0, 1, target, 1);
            @(negedge sys_clk);
            check_output("d_pop_valid", {63'b0, out_valid && out_ready}, 64'd1);
            lat = 0;
            for (int k = 1; k <= 6; k++) begin
                apply_stimulus(0, 0, 0, 1);
                @(negedge sys_clk);
                if (out_valid) begin
                    lat = k;
                    break;
                end
            end
            check_output("d_latency", 64'(lat), 64'd3);
            check_output("d_target", out_pc, {target[63:2], 2'b00});
        end

        // Reset mid-stream with the queue full.
        apply_stimulus(1, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0);
        repeat (8) apply_stimulus(0, 0, 0, 0);
        @(negedge sys_clk);
        check_output("e_full_valid", {63'b0, out_valid}, 64'd1);
        apply_stimulus(1, 0, 0, 0);
        @(negedge sys_clk);
        check_output("e_rst_en", {63'b0, imem_en}, 64'd0);
        apply_stimulus(1, 0, 0, 1);
        @(negedge sys_clk);
        check_output("e_after_valid", {63'b0, out_valid}, 64'd0);
        check_output("e_after_en", {63'b0, imem_en}, 64'd0);
        apply_stimulus(0, 0, 0, 1);
        @(negedge sys_clk);
        check_output("e_c0_en", {63'b0, imem_en}, 64'd1);
        check_output("e_c0_valid", {63'b0, out_valid}, 64'd0);
        apply_stimulus(0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 1);
        @(negedge sys_clk);
        check_output("e_c2_pc", out_pc, RESET_PC);

        // Randomized traffic: ready, redirects and occasional resets.
        repeat (400) begin
            rst    = ($urandom_range(0, 99) == 0);
            redir  = !rst && ($urandom_range(0, 15) == 0);
            target = {$urandom(), $urandom()};
            apply_stimulus(rst, redir, target, $urandom_range(0, 3) != 0);
        end
        repeat (8) apply_stimulus(0, 0, 0, 1);
        @(negedge sys_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
